uart_tx_fifo: RTL and testbench

//   Byte buffer and sequencer directly upstream of uart_tx. Accepts bytes from
//   the host side into a DEPTH-entry FIFO, then issues one single-cycle
//   i_Tx_DV/i_Tx_Byte strobe per byte to uart_tx. It waits for each frame to

---
 rtl/uart_tx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers host writes and issues one single-cycle
// DV strobe per byte, waiting for each serial frame to fully complete.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Wr_En,
    input  logic [7:0]        i_Wr_Data,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Busy,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STROBE    = 3'd1,
        S_WAIT_ACT  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    state_t            state_reg;
    state_t            state_next;
    logic              tx_dv_reg;
    logic [7:0]        tx_byte_reg;
    logic              overflow_reg;

    logic              full;
    logic              empty;
    logic              wr_accept;
    logic              pop;

    // Occupancy comes only from the count register so a wrapped pointer pair
    // can never be mistaken for empty.
    assign full      = (count_reg == COUNT_FULL);
    assign empty     = (count_reg == '0);
    assign wr_accept = i_Wr_En && !full;

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Never start while uart_tx is mid-frame or still in cleanup,
                // including a frame left running across our own reset.
                if (!empty && !i_Tx_Active && !i_Tx_Done) begin
                    pop        = 1'b1;
                    state_next = S_STROBE;
                end
            end
            S_STROBE:    state_next = S_WAIT_ACT;
            S_WAIT_ACT:  if (i_Tx_Active) state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (i_Tx_Done) state_next = S_GAP;
            S_GAP:       if (!i_Tx_Done && !i_Tx_Active) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({wr_accept, pop})
            2'b10:   count_next = count_reg + (ADDR_W + 1)'(1);
            2'b01:   count_next = count_reg - (ADDR_W + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg    <= S_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            tx_dv_reg    <= 1'b0;
            tx_byte_reg  <= 8'h00;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            tx_dv_reg    <= pop;
            overflow_reg <= i_Wr_En && full;
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + ADDR_W'(1);
                tx_byte_reg <= mem[rd_ptr_reg];
            end
        end
    end

    // Storage carries no reset so it maps onto RAM primitives.
    always_ff @(posedge i_Clock) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= i_Wr_Data;
        end
    end

    assign o_Full     = full;
    assign o_Empty    = empty;
    assign o_Count    = count_reg;
    assign o_Overflow = overflow_reg;
    assign o_Busy     = (state_reg != S_IDLE);
    assign o_Tx_DV    = tx_dv_reg;
    assign o_Tx_Byte  = tx_byte_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural uart_tx consumer plus a queue-based
// FIFO model checked every cycle, with directed and random write traffic.
module tb_uart_tx_fifo;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int CLKS_PER_BIT = 87;
    localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT;
    localparam int DRAIN_LIMIT  = 40000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              busy;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              cons_active = 1'b0;
    logic              cons_done = 1'b0;
    logic              ext_active = 1'b0;
    logic              tx_active;

    assign tx_active = cons_active | ext_active;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Wr_En     (wr_en),
        .i_Wr_Data   (wr_data),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (overflow),
        .o_Busy      (busy),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (cons_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural uart_tx: samples DV while idle, Active for the whole frame,
    // then Done high for two cycles (stop-bit end plus cleanup).
    initial begin
        forever begin
            @(negedge clk);
            if (tx_dv && !cons_active && !cons_done) begin
                @(posedge clk);
                #1 cons_active = 1'b1;
                repeat (FRAME_CLKS - 1) @(posedge clk);
                #1 cons_active = 1'b0;
                cons_done = 1'b1;
                repeat (2) @(posedge clk);
                #1 cons_done = 1'b0;
            end
        end
    end

    // Reference model: a byte queue updated once per clock edge.
    logic [7:0] model_q [$];
    int   dv_count  = 0;
    int   acc_count = 0;
    logic wr_en_s = 1'b0;
    logic [7:0] wr_data_s = 8'h00;
    logic act_s = 1'b0;
    logic done_s = 1'b0;
    logic done_last = 1'b0;
    logic dv_prev = 1'b0;
    logic dut_frame = 1'b0;
    logic fall_pending = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_q.delete();
                dv_prev      = 1'b0;
                dut_frame    = 1'b0;
                fall_pending = 1'b0;
            end else begin
                int   sz;
                logic popped;
                sz     = model_q.size();
                popped = tx_dv;
                check_eq("overflow", overflow, (wr_en_s && sz == DEPTH));
                if (fall_pending) begin
                    check_eq("dv_after_gap", popped, 1);
                end
                fall_pending = 1'b0;
                if (popped) begin
                    check_eq("dv_pulse", dv_prev, 0);
                    check_eq("dv_uart_idle", {act_s, done_s}, 2'b00);
                    check_eq("dv_nonempty", (sz > 0), 1);
                    if (sz > 0) begin
                        check_eq("tx_byte", tx_byte, model_q[0]);
                        void'(model_q.pop_front());
                    end
                    dv_count++;
                    dut_frame = 1'b1;
                end
                if (wr_en_s && sz < DEPTH) begin
                    model_q.push_back(wr_data_s);
                    acc_count++;
                end
                check_eq("count", count, model_q.size());
                check_eq("full", full, (model_q.size() == DEPTH));
                check_eq("empty", empty, (model_q.size() == 0));
                // A frame we started has ended: the next pending byte must go
                // out exactly one edge after Done is first seen low.
                if (dut_frame && done_last && !done_s && !act_s) begin
                    fall_pending = (model_q.size() > 0);
                    dut_frame    = 1'b0;
                end
                dv_prev = popped;
            end
            done_last = done_s;
            wr_en_s   = wr_en;
            wr_data_s = wr_data;
            act_s     = tx_active;
            done_s    = cons_done;
        end
    end

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((model_q.size() != 0 || tx_active || cons_done || busy || tx_dv) && n < DRAIN_LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_drain"}, (n < DRAIN_LIMIT), 1);
        check_eq({tag, "_empty"}, empty, 1);
    endtask

    initial begin
        int d0;
        int a0;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_dv", tx_dv, 0);
        check_eq("rst_byte", tx_byte, 8'h00);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_count", count, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single byte: DV one edge after the write edge, single cycle.
        wr(8'hA5);
        @(negedge clk);
        check_eq("t1_dv_k", tx_dv, 0);
        @(negedge clk);
        check_eq("t1_dv_k1", tx_dv, 1);
        check_eq("t1_byte", tx_byte, 8'hA5);
        @(negedge clk);
        check_eq("t1_dv_drop", tx_dv, 0);
        repeat (100) @(posedge clk);
        #1;
        check_eq("t1_busy_mid", busy, 1);
        wait_drain("t1");
        $display("t1 single byte: dv_count=%0d", dv_count);

        // Fill to full with the consumer held off, then one dropped write.
        ext_active = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'(i));
        check_eq("t2_full", full, 1);
        check_eq("t2_count", count, 16);
        wr(8'hFF);
        check_eq("t2_ovf", overflow, 1);
        check_eq("t2_count_ovf", count, 16);
        @(posedge clk);
        #1;
        check_eq("t2_ovf_clear", overflow, 0);
        d0 = dv_count;
        ext_active = 1'b0;
        wait_drain("t2");
        check_eq("t2_sent", dv_count - d0, 16);
        $display("t2 burst: sent=%0d", dv_count - d0);

        // Writes spanning a pop edge while draining.
        d0 = dv_count;
        for (int i = 0; i < 4; i++) wr(8'h30 + 8'(i));
        n = 0;
        while (!cons_done && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("t3_done_seen", (n < 5000), 1);
        for (int i = 0; i < 5; i++) wr(8'h40 + 8'(i));
        wait_drain("t3");
        check_eq("t3_sent", dv_count - d0, 9);
        $display("t3 write while draining: sent=%0d", dv_count - d0);

        // Reset in the middle of byte 2 of 4.
        d0 = dv_count;
        for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i));
        n = 0;
        while (!(dv_count >= d0 + 2 && cons_active) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("t4_reach", (n < 20000), 1);
        repeat (200) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("t4_rst_dv", tx_dv, 0);
        check_eq("t4_rst_byte", tx_byte, 8'h00);
        check_eq("t4_rst_ovf", overflow, 0);
        check_eq("t4_rst_busy", busy, 0);
        check_eq("t4_rst_empty", empty, 1);
        check_eq("t4_rst_full", full, 0);
        check_eq("t4_rst_count", count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        d0 = dv_count;
        wr(8'h5C);
        wait_drain("t4");
        check_eq("t4_sent", dv_count - d0, 1);
        $display("t4 reset mid-frame: sent after reset=%0d", dv_count - d0);

        // External Active held: nothing may be issued.
        ext_active = 1'b1;
        d0 = dv_count;
        wr(8'h71);
        wr(8'h72);
        repeat (60) @(posedge clk);
        #1;
        check_eq("t5_no_dv", dv_count - d0, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_count", count, 2);
        ext_active = 1'b0;
        wait_drain("t5");
        check_eq("t5_sent", dv_count - d0, 2);
        $display("t5 active held: sent after release=%0d", dv_count - d0);

        // Two bytes back to back.
        d0 = dv_count;
        wr(8'h81);
        wr(8'h82);
        wait_drain("t6");
        check_eq("t6_sent", dv_count - d0, 2);
        $display("t6 back-to-back: sent=%0d", dv_count - d0);

        // Random traffic.
        for (int r = 0; r < 3; r++) begin
            d0 = dv_count;
            a0 = acc_count;
            for (int c = 0; c < 24; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    wr(8'($urandom));
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
            wait_drain("rnd");
            check_eq("rnd_sent", dv_count - d0, acc_count - a0);
            $display("rnd round %0d: accepted=%0d sent=%0d", r, acc_count - a0, dv_count - d0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
